// File: rtl/collision_scanner_if.sv
// Handshake and result bundle between the game FSM and collision_scanner.
// The master drives the scan request and positions; the slave returns busy/done and the results.
interface collision_scanner_if #(
    parameter int N_ENEMY = 4
);
    logic                   start;
    logic [19:0]            position;
    logic [20*N_ENEMY-1:0]  e_pos;
    logic [N_ENEMY-1:0]     e_valid;
    logic                   busy;
    logic                   done;
    logic [N_ENEMY-1:0]     hit_mask;
    logic                   hit_any;
    logic [3:0]             hit_idx;
    logic [47:0]            tile_nbr;
    logic                   cooldown;

    modport master (
        output start, position, e_pos, e_valid,
        input  busy, done, hit_mask, hit_any, hit_idx, tile_nbr, cooldown
    );

    modport slave (
        input  start, position, e_pos, e_valid,
        output busy, done, hit_mask, hit_any, hit_idx, tile_nbr, cooldown
    );
endinterface

// File: rtl/collision_scanner.sv
// Serial player-vs-enemy box-overlap scanner (one enemy per clock) with neighbour-tile lookup.
// Optional hit cooldown enabled by defining COLLIDE_COOLDOWN_EN.
module collision_scanner_tile #(
    parameter int ORIGIN  = 0,
    parameter int OFFSET  = 0,
    parameter int TILE_SH = 5
) (
    input  logic [9:0] p,
    output logic [5:0] t
);
    // 12-bit two's complement keeps the sign of (p - ORIGIN + OFFSET) for clamping.
    logic [11:0] d;
    assign d = {2'b00, p} - 12'(ORIGIN) + 12'(OFFSET);
    assign t = d[11] ? 6'd0 : 6'(d >> TILE_SH);
endmodule

module collision_scanner #(
    parameter int N_ENEMY  = 4,
    parameter int SPRITE   = 16,
    parameter int TILE_SH  = 5,
    parameter int ORIGIN_X = 144,
    parameter int ORIGIN_Y = 31,
    parameter int COOLDOWN = 30
) (
    input  logic               clk,
    input  logic               rst,
    collision_scanner_if.slave bus
);
    localparam int IW    = (N_ENEMY > 1) ? $clog2(N_ENEMY) : 1;
    localparam int CNT_W = (COOLDOWN > 1) ? $clog2(COOLDOWN + 1) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SCAN = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]             state;
    logic [IW-1:0]          idx;
    logic                   last;
    logic [N_ENEMY-1:0]     raw, raw_next, rep_mask;
    logic [19:0]            pos_q;
    logic [20*N_ENEMY-1:0]  epos_q;
    logic [N_ENEMY-1:0]     evld_q;
    logic                   done_r, any_r;
    logic [N_ENEMY-1:0]     mask_r;
    logic [3:0]             idx_r, first;
    logic [47:0]            tile_r, tile_c;
    logic                   suppress;

    // Current enemy against the latched player, edge-inclusive in 11 bits so no wrap.
    logic [19:0] ep;
    logic [10:0] px, py, ex, ey;
    logic        hit_now;
    assign ep = epos_q[20*idx +: 20];
    assign px = {1'b0, pos_q[19:10]};
    assign py = {1'b0, pos_q[9:0]};
    assign ex = {1'b0, ep[19:10]};
    assign ey = {1'b0, ep[9:0]};
    assign hit_now = evld_q[idx]
                   && (ex <= px + 11'(SPRITE)) && (px <= ex + 11'(SPRITE))
                   && (ey <= py + 11'(SPRITE)) && (py <= ey + 11'(SPRITE));

    assign last = (idx == IW'(N_ENEMY - 1));

    always_comb begin
        raw_next = raw;
        if (hit_now) raw_next[idx] = 1'b1;
    end

    assign rep_mask = suppress ? '0 : raw_next;

    always_comb begin
        first = 4'd0;
        for (int k = N_ENEMY - 1; k >= 0; k--)
            if (rep_mask[k]) first = 4'(k);
    end

    // Neighbour tiles in output order up_x,up_y,rt_x,rt_y,dn_x,dn_y,lf_x,lf_y (even = x axis).
    function automatic int tile_off(input int j);
        case (j)
            1, 6:    return -1;
            2, 5:    return SPRITE + 1;
            default: return 0;
        endcase
    endfunction

    for (genvar j = 0; j < 8; j++) begin : g_tile
        collision_scanner_tile #(
            .ORIGIN  ((j % 2 == 0) ? ORIGIN_X : ORIGIN_Y),
            .OFFSET  (tile_off(j)),
            .TILE_SH (TILE_SH)
        ) u_tile (
            .p ((j % 2 == 0) ? pos_q[19:10] : pos_q[9:0]),
            .t (tile_c[47-6*j -: 6])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            idx    <= '0;
            raw    <= '0;
            pos_q  <= '0;
            epos_q <= '0;
            evld_q <= '0;
            done_r <= 1'b0;
            mask_r <= '0;
            any_r  <= 1'b0;
            idx_r  <= 4'd0;
            tile_r <= '0;
        end else begin
            done_r <= 1'b0;
            case (state)
                S_IDLE: if (bus.start) begin
                    pos_q  <= bus.position;
                    epos_q <= bus.e_pos;
                    evld_q <= bus.e_valid;
                    idx    <= '0;
                    raw    <= '0;
                    state  <= S_SCAN;
                end
                S_SCAN: begin
                    raw <= raw_next;
                    // Results land together with done in the DONE cycle.
                    if (last) begin
                        state  <= S_DONE;
                        done_r <= 1'b1;
                        mask_r <= rep_mask;
                        any_r  <= |rep_mask;
                        idx_r  <= first;
                        tile_r <= tile_c;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef COLLIDE_COOLDOWN_EN
    logic [CNT_W-1:0] cd_cnt;
    assign suppress     = (cd_cnt != '0);
    assign bus.cooldown = suppress;

    always_ff @(posedge clk) begin
        if (rst)
            cd_cnt <= '0;
        else if (state == S_SCAN && last) begin
            if (suppress)       cd_cnt <= cd_cnt - 1'b1;
            else if (|raw_next) cd_cnt <= CNT_W'(COOLDOWN);
        end
    end
`else
    logic [CNT_W-1:0] unused_cooldown;
    assign unused_cooldown = CNT_W'(COOLDOWN);
    assign suppress        = 1'b0;
    assign bus.cooldown    = 1'b0;
`endif

    assign bus.busy     = (state != S_IDLE);
    assign bus.done     = done_r;
    assign bus.hit_mask = mask_r;
    assign bus.hit_any  = any_r;
    assign bus.hit_idx  = idx_r;
    assign bus.tile_nbr = tile_r;
endmodule

// File: tb/tb_collision_scanner.sv
// Self-checking bench for collision_scanner: vector table, corner sequences and random scans vs a model.
// Cooldown expectations follow COLLIDE_COOLDOWN_EN when it is defined for the build.
module tb_collision_scanner;
    localparam int N        = 4;
    localparam int SPRITE   = 16;
    localparam int OX       = 144;
    localparam int OY       = 31;
    localparam int COOLDOWN = 2;
    localparam logic [19:0] FAR = {10'd900, 10'd900};

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    collision_scanner_if #(.N_ENEMY(N)) bus ();

    collision_scanner #(
        .N_ENEMY(N), .SPRITE(SPRITE), .TILE_SH(5),
        .ORIGIN_X(OX), .ORIGIN_Y(OY), .COOLDOWN(COOLDOWN)
    ) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    int checks = 0;
    int failures = 0;
`ifdef COLLIDE_COOLDOWN_EN
    int cd = 0;
`endif

    typedef struct {
        logic [19:0]    pos;
        logic [20*N-1:0] epos;
        logic [N-1:0]   ev;
        logic [N-1:0]   mask;
        logic [3:0]     idx;
        logic [47:0]    tile;
        logic           chk_tile;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [19:0] xy(input int x, input int y);
        return {10'(x), 10'(y)};
    endfunction

    function automatic logic [N-1:0] model_mask(input logic [19:0] p, input logic [20*N-1:0] ep,
                                                 input logic [N-1:0] ev);
        logic [N-1:0] m;
        int px, py, ex, ey, dx, dy;
        m  = '0;
        px = int'(p[19:10]);
        py = int'(p[9:0]);
        for (int i = 0; i < N; i++) begin
            ex = int'(ep[20*i+10 +: 10]);
            ey = int'(ep[20*i +: 10]);
            dx = (ex > px) ? ex - px : px - ex;
            dy = (ey > py) ? ey - py : py - ey;
            m[i] = ev[i] && dx <= SPRITE && dy <= SPRITE;
        end
        return m;
    endfunction

    function automatic logic [5:0] tc(input int v);
        return (v < 0) ? 6'd0 : 6'((v / 32) % 64);
    endfunction

    function automatic logic [47:0] model_tile(input logic [19:0] p);
        int x, y;
        x = int'(p[19:10]) - OX;
        y = int'(p[9:0]) - OY;
        return {tc(x), tc(y - 1), tc(x + SPRITE + 1), tc(y),
                tc(x), tc(y + SPRITE + 1), tc(x - 1), tc(y)};
    endfunction

    task automatic check_model(input string tag, input logic [19:0] p, input logic [20*N-1:0] ep,
                               input logic [N-1:0] ev);
        logic [N-1:0] m;
        logic [3:0]   lo;
        logic         exp_cd;
        logic         found;
        m = model_mask(p, ep, ev);
`ifdef COLLIDE_COOLDOWN_EN
        if (cd > 0) begin
            m = '0;
            cd--;
        end else if (m != '0) begin
            cd = COOLDOWN;
        end
        exp_cd = (cd > 0);
`else
        exp_cd = 1'b0;
`endif
        lo = 4'd0;
        found = 1'b0;
        for (int i = 0; i < N; i++)
            if (m[i] && !found) begin
                lo = 4'(i);
                found = 1'b1;
            end
        chk({tag, ".mask"}, 64'(bus.hit_mask), 64'(m));
        chk({tag, ".any"},  64'(bus.hit_any),  64'(found));
        chk({tag, ".idx"},  64'(bus.hit_idx),  64'(lo));
        chk({tag, ".tile"}, 64'(bus.tile_nbr), 64'(model_tile(p)));
        chk({tag, ".cooldown"}, 64'(bus.cooldown), 64'(exp_cd));
    endtask

    task automatic reset_pulse(input int cycles);
        rst = 1'b1;
        repeat (cycles) @(posedge clk);
        #1 rst = 1'b0;
`ifdef COLLIDE_COOLDOWN_EN
        cd = 0;
`endif
    endtask

    task automatic check_idle_zero(input string tag);
        chk({tag, ".busy"},     64'(bus.busy),     64'd0);
        chk({tag, ".done"},     64'(bus.done),     64'd0);
        chk({tag, ".mask"},     64'(bus.hit_mask), 64'd0);
        chk({tag, ".any"},      64'(bus.hit_any),  64'd0);
        chk({tag, ".idx"},      64'(bus.hit_idx),  64'd0);
        chk({tag, ".tile"},     64'(bus.tile_nbr), 64'd0);
        chk({tag, ".cooldown"}, 64'(bus.cooldown), 64'd0);
    endtask

    // Called just after an edge with the DUT idle; returns after done has dropped.
    task automatic do_scan(input logic [19:0] p, input logic [20*N-1:0] ep, input logic [N-1:0] ev,
                           output int lat, output logic cd_at_start);
        bus.position = p;
        bus.e_pos    = ep;
        bus.e_valid  = ev;
        bus.start    = 1'b1;
        @(posedge clk);
        #1;
        bus.start   = 1'b0;
        cd_at_start = bus.cooldown;
        chk("scan.busy_after_accept", 64'(bus.busy), 64'd1);
        lat = -1;
        for (int k = 1; k <= 3 * N; k++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                lat = k;
                break;
            end
        end
        chk("scan.latency", 64'(lat), 64'(N));
    endtask

    task automatic finish_scan();
        @(posedge clk);
        #1;
        chk("scan.done_one_cycle", 64'(bus.done), 64'd0);
        chk("scan.idle_after",     64'(bus.busy), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[8];
        int lat, dones, last_e, exp_dones;
        logic cda;
        logic [19:0] p;
        logic [20*N-1:0] ep, epa, epb;
        logic [N-1:0] ev;
        logic [3:0] any_seq, cd_seq;

        vt[0] = '{xy(200,100), {FAR, xy(216,116), FAR, FAR},      4'hF,    4'b0100, 4'd2, 48'd0, 1'b0};
        vt[1] = '{xy(200,100), {FAR, FAR, FAR, xy(216,100)},      4'hF,    4'b0001, 4'd0, 48'd0, 1'b0};
        vt[2] = '{xy(200,100), {FAR, FAR, FAR, xy(217,100)},      4'hF,    4'b0000, 4'd0, 48'd0, 1'b0};
        vt[3] = '{xy(200,100), {FAR, FAR, FAR, xy(216,100)},      4'b1110, 4'b0000, 4'd0, 48'd0, 1'b0};
        vt[4] = '{xy(144,31),  {FAR, FAR, FAR, FAR},              4'hF,    4'b0000, 4'd0, 48'd0, 1'b1};
        vt[5] = '{xy(176,95),  {FAR, FAR, FAR, FAR},              4'hF,    4'b0000, 4'd0,
                  {6'd1, 6'd1, 6'd1, 6'd2, 6'd1, 6'd2, 6'd0, 6'd2}, 1'b1};
        vt[6] = '{xy(300,300), {xy(284,316), FAR, xy(290,310), xy(283,300)}, 4'hF, 4'b1010, 4'd1, 48'd0, 1'b0};
        vt[7] = '{xy(200,100), {FAR, FAR, xy(200,83), xy(184,84)}, 4'hF,   4'b0001, 4'd0, 48'd0, 1'b0};

        bus.start = 1'b0;
        bus.position = '0;
        bus.e_pos = '0;
        bus.e_valid = '0;
        reset_pulse(3);
        check_idle_zero("reset");

        // Reset two cycles into a scan: everything clears and the scan never completes.
        epa = {FAR, xy(216,116), FAR, FAR};
        bus.position = xy(200,100);
        bus.e_pos = epa;
        bus.e_valid = 4'hF;
        bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        @(posedge clk);
        #1;
        reset_pulse(2);
        check_idle_zero("midscan_reset");
        dones = 0;
        repeat (10) begin
            @(posedge clk);
            #1 if (bus.done) dones++;
        end
        chk("midscan_reset.no_done", 64'(dones), 64'd0);

        // start held high: one done every N+2 cycles, inputs changed mid-scan ignored.
        epb = {FAR, FAR, FAR, FAR};
        bus.position = xy(200,100);
        bus.e_pos = epa;
        bus.e_valid = 4'hF;
        bus.start = 1'b1;
        dones = 0;
        last_e = 0;
        for (int e = 0; e < 20; e++) begin
            @(posedge clk);
            #1;
            if (e == 2) bus.e_pos = epb;
            if (bus.done) begin
                if (dones > 0) chk("held.interval", 64'(e - last_e), 64'(N + 2));
                else chk("held.first_edge", 64'(e), 64'(N));
                check_model("held", xy(200,100), (dones == 0) ? epa : epb, 4'hF);
                dones++;
                last_e = e;
            end
        end
        bus.start = 1'b0;
        exp_dones = 0;
        for (int k = 0; k * (N + 2) + N <= 19; k++) exp_dones++;
        chk("held.done_count", 64'(dones), 64'(exp_dones));
        for (int k = 0; k < 3 * N && (bus.busy || bus.done); k++) begin
            @(posedge clk);
            #1 if (bus.done) check_model("held_drain", xy(200,100), epb, 4'hF);
        end
        chk("held.drained", 64'(bus.busy), 64'd0);

        // Vector table, each from a fresh reset.
        for (int v = 0; v < 8; v++) begin
            reset_pulse(1);
            do_scan(vt[v].pos, vt[v].epos, vt[v].ev, lat, cda);
            chk($sformatf("vec%0d.mask", v), 64'(bus.hit_mask), 64'(vt[v].mask));
            chk($sformatf("vec%0d.any", v),  64'(bus.hit_any),  64'(vt[v].mask != '0));
            chk($sformatf("vec%0d.idx", v),  64'(bus.hit_idx),  64'(vt[v].idx));
            if (vt[v].chk_tile) chk($sformatf("vec%0d.tile", v), 64'(bus.tile_nbr), 64'(vt[v].tile));
            finish_scan();
        end

        // Permanent overlap over four scans.
        reset_pulse(1);
        for (int s = 0; s < 4; s++) begin
            do_scan(xy(400,400), {FAR, FAR, FAR, xy(405,395)}, 4'h1, lat, cda);
            any_seq[s] = bus.hit_any;
            cd_seq[s] = cda;
            check_model($sformatf("perm%0d", s), xy(400,400), {FAR, FAR, FAR, xy(405,395)}, 4'h1);
            finish_scan();
        end
`ifdef COLLIDE_COOLDOWN_EN
        chk("perm.any_seq",      64'(any_seq),   64'(4'b1001));
        chk("perm.cooldown_seq", 64'(cd_seq[3:1]), 64'(3'b011));
`else
        chk("perm.any_seq",      64'(any_seq), 64'(4'b1111));
        chk("perm.cooldown_seq", 64'(cd_seq),  64'(4'b0000));
`endif

        // Random scans against the model, cooldown state carried across.
        for (int r = 0; r < 40; r++) begin
            int px, py;
            px = $urandom_range(150, 800);
            py = $urandom_range(40, 800);
            p = xy(px, py);
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 3) == 0)
                    ep[20*i +: 20] = xy($urandom_range(0, 1023), $urandom_range(0, 1023));
                else
                    ep[20*i +: 20] = xy(px + $urandom_range(0, 40) - 20, py + $urandom_range(0, 40) - 20);
            end
            ev = N'($urandom);
            do_scan(p, ep, ev, lat, cda);
            check_model($sformatf("rand%0d", r), p, ep, ev);
            finish_scan();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
